// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking layer: FSM encoding, width calc, saturating add.
// Combinational helpers only; no latency, no backpressure.
package snn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_UPDATE,
        S_DONE
    } state_t;

    function automatic int acc_width(input int dw, input int int_dw);
        return dw + int_dw;
    endfunction

    // Index width that never collapses to zero for single-entry arrays.
    function automatic int clog2m1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Symmetric clamp to +/-(2^(w-1)-1); callers keep w well below 64.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] lim;
        logic signed [63:0] s;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        s   = a + b;
        if (s > lim)
            return lim;
        if (s < -lim)
            return -lim;
        return s;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: leak, saturating integrate, threshold and refractory count.
// State commits on the update strobe only; no backpressure.
module lif_neuron
    import snn_pkg::*;
#(
    parameter  int ACC_W      = 24,
    parameter  int LEAK_SHIFT = 4,
    parameter  int THRESH     = 6000,
    parameter  int REFRAC     = 2,
    localparam int RW         = clog2m1(REFRAC + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    update,
    input  logic signed [ACC_W-1:0] sum,
    input  logic                    inhibit,
    output logic                    cand,
    output logic signed [ACC_W-1:0] v
);

    logic signed [ACC_W-1:0] v_q;
    logic signed [ACC_W-1:0] v_leak;
    logic signed [ACC_W-1:0] v_next;
    logic [RW-1:0]           refrac_q;

    // Subtracting V>>>k only shrinks magnitude, so only the add of sum can overflow.
    assign v_leak = v_q - (v_q >>> LEAK_SHIFT);
    assign v_next = ACC_W'(sat_add(64'(v_leak), 64'(sum), ACC_W));
    assign cand   = (refrac_q == '0) && (v_next >= ACC_W'(THRESH));
    assign v      = v_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q      <= '0;
            refrac_q <= '0;
        end else if (update) begin
            if (refrac_q != '0) begin
                v_q      <= '0;
                refrac_q <= refrac_q - RW'(1);
            end else if (cand) begin
                // A WTA loser is silenced but stays free to integrate next step.
                v_q <= '0;
                if (!inhibit)
                    refrac_q <= RW'(REFRAC);
            end else begin
                v_q <= v_next;
            end
        end
    end

endmodule

// File: rtl/snn_layer_wta.sv
// Time-stepped LIF layer with writable weights and optional winner-take-all.
// Start in cycle 0 gives done in cycle INPUTNUM+2; starts outside IDLE are dropped, no queueing.
module snn_layer_wta
    import snn_pkg::*;
#(
    parameter  int DW         = 16,
    parameter  int INT_DW     = 8,
    parameter  int INPUTNUM   = 4,
    parameter  int EXCNUM     = 2,
    parameter  int LEAK_SHIFT = 4,
    parameter  int THRESH     = 6000,
    parameter  int REFRAC     = 2,
    parameter  int W_INIT     = 2000,
    localparam int ACC_W      = acc_width(DW, INT_DW),
    localparam int IW         = clog2m1(INPUTNUM),
    localparam int OW         = clog2m1(EXCNUM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [INPUTNUM-1:0]     in_spikes,
    input  logic                    wta_en,
    output logic                    busy,
    output logic                    done,
    output logic [EXCNUM-1:0]       out_spikes,
    input  logic                    w_we,
    input  logic [IW-1:0]           w_in_idx,
    input  logic [OW-1:0]           w_out_idx,
    input  logic signed [DW-1:0]    w_data,
    input  logic [OW-1:0]           v_sel,
    output logic signed [ACC_W-1:0] v_mem
);

    state_t                  state_q, state_d;
    logic [IW-1:0]           cnt_q;
    logic [INPUTNUM-1:0]     spk_q;
    logic                    wta_q;
    logic signed [DW-1:0]    w_q     [INPUTNUM][EXCNUM];
    logic signed [ACC_W-1:0] sum_q   [EXCNUM];
    logic signed [ACC_W-1:0] sum_nxt [EXCNUM];
    logic signed [ACC_W-1:0] v_all   [EXCNUM];
    logic [EXCNUM-1:0]       cand, winner, inhibit;
    logic                    accept, update;

    assign accept = (state_q == S_IDLE) && start;
    assign update = (state_q == S_UPDATE);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_ACCUM;
            S_ACCUM:  if (cnt_q == IW'(INPUTNUM - 1)) state_d = S_UPDATE;
            S_UPDATE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Lowest-index candidate wins; the rest are inhibited only when WTA is armed.
    assign winner  = cand & (~cand + EXCNUM'(1));
    assign inhibit = {EXCNUM{wta_q}} & cand & ~winner;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            spk_q      <= '0;
            wta_q      <= 1'b0;
            out_spikes <= '0;
            for (int n = 0; n < EXCNUM; n++)
                sum_q[n] <= '0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
                spk_q <= in_spikes;
                wta_q <= wta_en;
                for (int n = 0; n < EXCNUM; n++)
                    sum_q[n] <= '0;
            end else if (state_q == S_ACCUM) begin
                cnt_q <= cnt_q + IW'(1);
                for (int n = 0; n < EXCNUM; n++)
                    sum_q[n] <= sum_nxt[n];
            end
            if (update)
                out_spikes <= wta_q ? winner : cand;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < INPUTNUM; i++)
                for (int n = 0; n < EXCNUM; n++)
                    w_q[i][n] <= DW'(W_INIT);
        end else if (w_we && !busy && (int'(w_in_idx) < INPUTNUM) && (int'(w_out_idx) < EXCNUM)) begin
            w_q[w_in_idx][w_out_idx] <= w_data;
        end
    end

    for (genvar n = 0; n < EXCNUM; n++) begin : g_neuron
        assign sum_nxt[n] = ACC_W'(sat_add(64'(sum_q[n]),
                                           spk_q[cnt_q] ? 64'(w_q[cnt_q][n]) : 64'sd0,
                                           ACC_W));

        lif_neuron #(
            .ACC_W      (ACC_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .THRESH     (THRESH),
            .REFRAC     (REFRAC)
        ) u_lif (
            .clk     (clk),
            .rst     (rst),
            .update  (update),
            .sum     (sum_q[n]),
            .inhibit (inhibit[n]),
            .cand    (cand[n]),
            .v       (v_all[n])
        );
    end

    always_comb begin
        v_mem = '0;
        for (int n = 0; n < EXCNUM; n++)
            if (v_sel == OW'(n))
                v_mem = v_all[n];
    end

endmodule

// File: tb/tb_snn_layer_wta.sv
// Directed bench: default layer plus a narrow-accumulator instance for saturation cases.
module tb_snn_layer_wta;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               wta_en = 1'b0;
    logic               w_we = 1'b0;
    logic [3:0]         in_spikes = '0;
    logic [1:0]         w_in_idx = '0;
    logic               w_out_idx = 1'b0;
    logic signed [15:0] w_data = '0;
    logic               v_sel = 1'b0;

    logic               busy_a, done_a, busy_b, done_b;
    logic [1:0]         out_a, out_b;
    logic signed [23:0] v_a;
    logic signed [17:0] v_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snn_layer_wta u_dut_a (
        .clk(clk), .rst(rst), .start(start), .in_spikes(in_spikes), .wta_en(wta_en),
        .busy(busy_a), .done(done_a), .out_spikes(out_a),
        .w_we(w_we), .w_in_idx(w_in_idx), .w_out_idx(w_out_idx), .w_data(w_data),
        .v_sel(v_sel), .v_mem(v_a)
    );

    snn_layer_wta #(
        .INT_DW(2), .LEAK_SHIFT(17), .THRESH(131071), .W_INIT(32767)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .in_spikes(in_spikes), .wta_en(wta_en),
        .busy(busy_b), .done(done_b), .out_spikes(out_b),
        .w_we(w_we), .w_in_idx(w_in_idx), .w_out_idx(w_out_idx), .w_data(w_data),
        .v_sel(v_sel), .v_mem(v_b)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic wr(input logic [1:0] i, input logic o, input logic signed [15:0] d);
        w_in_idx = i; w_out_idx = o; w_data = d; w_we = 1'b1;
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic start_step(input logic [3:0] in, input logic wta);
        int g = 0;
        while (busy_a && g < 30) begin
            @(posedge clk); #1;
            g++;
        end
        start = 1'b1; in_spikes = in; wta_en = wta;
        @(posedge clk); #1;
        start = 1'b0; in_spikes = '0; wta_en = 1'b0;
    endtask

    // Returns the cycle (accept cycle = 0) in which done was seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_a && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", done_a, 1);
    endtask

    task automatic do_step(input logic [3:0] in, input logic wta, output int cyc);
        start_step(in, wta);
        wait_done(cyc);
    endtask

    task automatic rd_v(input int n, output logic signed [63:0] a, output logic signed [63:0] b);
        v_sel = n[0];
        #1;
        a = v_a;
        b = v_b;
    endtask

    logic signed [63:0] exp_v0  [7] = '{2000, 3875, 5633, 0, 0, 0, 2000};
    logic signed [63:0] exp_out [7] = '{0, 0, 0, 3, 0, 0, 0};

    initial begin
        int cyc;
        int dcount;
        logic signed [63:0] a, b;

        // Reset state
        do_reset();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_out", out_a, 0);
        rd_v(0, a, b);
        chk("rst_v0", a, 0);

        // All inputs, no WTA: both neurons cross threshold
        start_step(4'b1111, 1'b0);
        chk("t1_busy_c1", busy_a, 1);
        wait_done(cyc);
        chk("t1_latency", cyc, 6);
        chk("t1_out", out_a, 2'b11);
        rd_v(0, a, b); chk("t1_v0", a, 0);
        rd_v(1, a, b); chk("t1_v1", a, 0);
        @(posedge clk); #1;
        chk("t1_idle_busy", busy_a, 0);

        // Single input repeated: leak, fire, refractory, resume
        do_reset();
        for (int s = 0; s < 7; s++) begin
            do_step(4'b0001, 1'b0, cyc);
            rd_v(0, a, b);
            chk($sformatf("t2_v0_s%0d", s + 1), a, exp_v0[s]);
            chk($sformatf("t2_out_s%0d", s + 1), out_a, exp_out[s]);
        end

        // WTA: neuron 0 wins, neuron 1 silenced without refractory
        do_reset();
        do_step(4'b1111, 1'b1, cyc);
        chk("t3_out", out_a, 2'b01);
        rd_v(1, a, b); chk("t3_v1", a, 0);
        do_step(4'b0001, 1'b0, cyc);
        chk("t3_next_out", out_a, 0);
        rd_v(0, a, b); chk("t3_next_v0_refrac", a, 0);
        rd_v(1, a, b); chk("t3_next_v1_free", a, 2000);

        // Weight write while idle, then a write attempt while busy
        do_reset();
        wr(2'd0, 1'b1, -16'sd3000);
        do_step(4'b0001, 1'b0, cyc);
        chk("t4_out", out_a, 0);
        rd_v(0, a, b); chk("t4_v0", a, 2000);
        rd_v(1, a, b); chk("t4_v1", a, -3000);
        start_step(4'b0001, 1'b0);
        wr(2'd0, 1'b1, 16'sd5000);
        wait_done(cyc);
        rd_v(0, a, b); chk("t4_busy_v0", a, 3875);
        rd_v(1, a, b); chk("t4_busy_v1", a, -5812);

        // Saturation on the 18-bit instance
        do_reset();
        for (int i = 0; i < 4; i++)
            wr(i[1:0], 1'b1, 16'sh8000);
        do_step(4'b1111, 1'b0, cyc);
        chk("t5_out_s1", out_b, 0);
        rd_v(0, a, b); chk("t5_v0_s1", b, 131068);
        rd_v(1, a, b); chk("t5_v1_neg_clamp", b, -131071);
        do_step(4'b1111, 1'b0, cyc);
        chk("t5_out_s2", out_b, 2'b01);
        rd_v(0, a, b); chk("t5_v0_s2", b, 0);
        rd_v(1, a, b); chk("t5_v1_s2", b, -131071);

        // Reset during ACCUM cycle 2
        do_reset();
        wr(2'd0, 1'b1, -16'sd3000);
        start_step(4'b0001, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("t6_busy", busy_a, 0);
        chk("t6_out", out_a, 0);
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (done_a) dcount++;
            @(posedge clk); #1;
        end
        chk("t6_no_done", dcount, 0);
        do_step(4'b0001, 1'b0, cyc);
        chk("t6_latency", cyc, 6);
        rd_v(0, a, b); chk("t6_v0", a, 2000);
        rd_v(1, a, b); chk("t6_v1_winit", a, 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
